vga_timing_gen: RTL and testbench
=================================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter H_VISIBLE, 640, visible pixels per line.
REQ-002 Parameter H_FRONT, 16, horizontal front porch in pixels.
REQ-003 Parameter H_SYNC, 96, horizontal sync width in pixels.
REQ-004 Parameter H_BACK, 48, horizontal back porch in pixels.
REQ-005 Parameter V_VISIBLE, 480, visible lines per frame.
REQ-006 Parameter V_FRONT, 10, vertical front porch in lines.
REQ-007 Parameter V_SYNC, 2, vertical sync width in lines.
REQ-008 Parameter V_BACK, 33, vertical back porch in lines.
REQ-009 clk  input  1  pixel clock; all state updates on the rising edge.
REQ-010 rst_n  input  1  asynchronous, active-low reset.
REQ-011 ena  input  1  pixel advance enable; when low, all state holds.
REQ-012 x  output  10  current horizontal pixel position; feeds overlay x.
REQ-013 y  output  10  current line position; feeds overlay y.
REQ-014 hsync  output  1  horizontal sync, active low.
REQ-015 vsync  output  1  vertical sync, active low.
REQ-016 display_on  output  1  high when x < H_VISIBLE and y < V_VISIBLE.
REQ-017 line_start  output  1  one-cycle pulse when x==0.
REQ-018 frame_start  output  1  one-cycle pulse when x==0 and y==0.
REQ-019 frame_count  output  8  count of completed frames, wraps modulo 256.

Function
REQ-020 The module SHALL define H_TOTAL = sum of the four H parameters (800) and V_TOTAL = sum of the four V parameters (525).
REQ-021 x SHALL increment by 1 on each clk edge with ena high, and SHALL wrap from H_TOTAL-1 to 0.
REQ-022 y SHALL increment by 1 only on the edge where x wraps, and SHALL wrap from V_TOTAL-1 to 0 on that same edge.
REQ-023 frame_count SHALL increment by 1 on the edge where both x and y wrap; 255 SHALL wrap to 0.
REQ-024 hsync and vsync SHALL be registered outputs, aligned so they correspond to the x/y values visible in the same cycle (zero relative skew).
REQ-025 hsync SHALL be 0 exactly when x is in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1] = [656,751], and 1 otherwise.
REQ-026 vsync SHALL be 0 exactly when y is in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC-1] = [490,491], and 1 otherwise.
REQ-027 display_on, line_start and frame_start SHALL be derived from the registered x/y state in the same cycle, with no extra latency.
REQ-028 line_start and frame_start SHALL each be high for exactly one ena-qualified pixel per occurrence. While ena is low, these outputs reflect the held state.
REQ-029 When ena is low, x, y, hsync, vsync and frame_count SHALL hold their values. When ena returns high, counting SHALL resume from the held position with no skipped or repeated pixel.
REQ-030 Counter widths SHALL be 10 bits. The compare logic SHALL be correct for any parameter set with totals up to 1024.

Reset
REQ-031 While rst_n is low, the following SHALL hold regardless of clk or ena:
- x = 0, y = 0
- hsync = 1, vsync = 1
- frame_count = 0
- display_on = 1, line_start = 1, frame_start = 1
REQ-032 Reset asserted mid-frame SHALL take effect immediately, without waiting for a clock edge. The first ena-qualified edge after release SHALL produce x = 1, y = 0.
REQ-033 No output SHALL glitch to an out-of-range value (x ≥ H_TOTAL or y ≥ V_TOTAL) at any time.

Verification
REQ-034 Hold ena=1 after reset for 800 clocks:
- x sequences 0..799 then 0, and y steps 0→1.
- hsync is low for exactly 96 clocks, starting at x=656.
- line_start pulses twice (x=0 at start and after the wrap).
REQ-035 Run one full frame of 420000 clocks:
- vsync is low for exactly 1600 clocks, covering y=490..491.
- frame_start pulses at clock 0 and clock 420000.
- frame_count goes 0→1.
REQ-036 Check display_on and boundaries:
- display_on=1 at (639,479); 0 at (640,479), (0,480) and (799,524).
- From (799,524), the next edge gives (0,0) with frame_start=1.
REQ-037 Toggle ena low for 7 clocks at x=655: x holds at 655 and hsync stays 1. When ena rises, the next edges give 656 (hsync=0), then 657.
REQ-038 Assert rst_n low asynchronously at (300,200) between clock edges:
- Outputs go immediately to the reset values, and frame_count=0.
- After release, counting restarts from (0,0).
REQ-039 Force frame_count to 255 by running 256 frames (or preloading it in the bench): the next frame wrap gives frame_count=0.

Source files
------------

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel/line counters, registered active-low syncs,
// display-enable, line/frame start strobes and a wrapping frame counter.
module vga_timing_gen #(
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_VISIBLE = 480,
    parameter int unsigned V_FRONT   = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 33
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       ena_i,
    output logic [9:0] x_o,
    output logic [9:0] y_o,
    output logic       hsync_o,
    output logic       vsync_o,
    output logic       display_on_o,
    output logic       line_start_o,
    output logic       frame_start_o,
    output logic [7:0] frame_count_o
);

    localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    // 11-bit constants so totals of exactly 1024 still compare correctly.
    localparam logic [10:0] HLast      = 11'(H_TOTAL - 1);
    localparam logic [10:0] VLast      = 11'(V_TOTAL - 1);
    localparam logic [10:0] HVis       = 11'(H_VISIBLE);
    localparam logic [10:0] VVis       = 11'(V_VISIBLE);
    localparam logic [10:0] HSyncStart = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0] HSyncEnd   = 11'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [10:0] VSyncStart = 11'(V_VISIBLE + V_FRONT);
    localparam logic [10:0] VSyncEnd   = 11'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [9:0] x_q, x_d;
    logic [9:0] y_q, y_d;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    logic [7:0] fc_q, fc_d;
    logic       x_wrap, y_wrap;

    always_comb begin
        x_wrap = ({1'b0, x_q} == HLast);
        y_wrap = ({1'b0, y_q} == VLast);
        x_d    = x_q;
        y_d    = y_q;
        fc_d   = fc_q;
        if (ena_i) begin
            if (x_wrap) begin
                x_d = '0;
                if (y_wrap) begin
                    y_d  = '0;
                    fc_d = fc_q + 8'd1;
                end else begin
                    y_d = y_q + 10'd1;
                end
            end else begin
                x_d = x_q + 10'd1;
            end
        end
        // Syncs decoded from the next position so the registers line up with x/y.
        hsync_d = !(({1'b0, x_d} >= HSyncStart) && ({1'b0, x_d} < HSyncEnd));
        vsync_d = !(({1'b0, y_d} >= VSyncStart) && ({1'b0, y_d} < VSyncEnd));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            x_q     <= '0;
            y_q     <= '0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            fc_q    <= '0;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            fc_q    <= fc_d;
        end
    end

    always_comb begin
        x_o           = x_q;
        y_o           = y_q;
        hsync_o       = hsync_q;
        vsync_o       = vsync_q;
        frame_count_o = fc_q;
        display_on_o  = ({1'b0, x_q} < HVis) && ({1'b0, y_q} < VVis);
        line_start_o  = (x_q == 10'd0);
        frame_start_o = (x_q == 10'd0) && (y_q == 10'd0);
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: a full-size VGA instance plus a tiny-raster instance so frame
// wraps and frame_count rollover are reachable in a short run.
module tb_vga_timing_gen;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       hs;
        logic       vs;
        logic       de;
        logic       ls;
        logic       fs;
        logic [7:0] fc;
    } obs_t;

    // Tiny raster: 8 pixels x 7 lines, hsync on x=5..6, vsync on y=4..5.
    localparam int unsigned SHV = 4, SHF = 1, SHS = 2, SHB = 1;
    localparam int unsigned SVV = 3, SVF = 1, SVS = 2, SVB = 1;

    logic       clk, rst_n, ena;
    logic [9:0] ax, ay, bx, by;
    logic       ahs, avs, ade, als, afs, bhs, bvs, bde, bls, bfs;
    logic [7:0] afc, bfc;

    obs_t q_a[$];
    obs_t q_b[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   pos_a = 0, fr_a = 0, pos_b = 0, fr_b = 0;

    vga_timing_gen u_dflt (
        .clk_i(clk), .rst_ni(rst_n), .ena_i(ena), .x_o(ax), .y_o(ay),
        .hsync_o(ahs), .vsync_o(avs), .display_on_o(ade), .line_start_o(als),
        .frame_start_o(afs), .frame_count_o(afc)
    );

    vga_timing_gen #(
        .H_VISIBLE(SHV), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
        .V_VISIBLE(SVV), .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB)
    ) u_small (
        .clk_i(clk), .rst_ni(rst_n), .ena_i(ena), .x_o(bx), .y_o(by),
        .hsync_o(bhs), .vsync_o(bvs), .display_on_o(bde), .line_start_o(bls),
        .frame_start_o(bfs), .frame_count_o(bfc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected outputs from a linear pixel index within the frame.
    function automatic obs_t model(int pos, int frames, int hv, int hf, int hsw, int hb,
                                   int vv, int vf, int vsw);
        obs_t o;
        int   ht = hv + hf + hsw + hb;
        int   xx = pos % ht;
        int   yy = pos / ht;
        o.x  = 10'(xx);
        o.y  = 10'(yy);
        o.hs = !(xx >= hv + hf && xx < hv + hf + hsw);
        o.vs = !(yy >= vv + vf && yy < vv + vf + vsw);
        o.de = (xx < hv) && (yy < vv);
        o.ls = (xx == 0);
        o.fs = (pos == 0);
        o.fc = 8'(frames % 256);
        return o;
    endfunction

    function automatic obs_t exp_a();
        return model(pos_a, fr_a, 640, 16, 96, 48, 480, 10, 2);
    endfunction

    function automatic obs_t exp_b();
        return model(pos_b, fr_b, SHV, SHF, SHS, SHB, SVV, SVF, SVS);
    endfunction

    function automatic obs_t obs_a();
        obs_t o;
        o = '{x: ax, y: ay, hs: ahs, vs: avs, de: ade, ls: als, fs: afs, fc: afc};
        return o;
    endfunction

    function automatic obs_t obs_b();
        obs_t o;
        o = '{x: bx, y: by, hs: bhs, vs: bvs, de: bde, ls: bls, fs: bfs, fc: bfc};
        return o;
    endfunction

    task automatic compare(input string name, input obs_t act, input obs_t exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got x=%0d y=%0d hs=%b vs=%b de=%b ls=%b fs=%b fc=%0d ; %s",
                     name, $time, act.x, act.y, act.hs, act.vs, act.de, act.ls, act.fs,
                     act.fc, $sformatf("want x=%0d y=%0d hs=%b vs=%b de=%b ls=%b fs=%b fc=%0d",
                     exp.x, exp.y, exp.hs, exp.vs, exp.de, exp.ls, exp.fs, exp.fc));
        end
    endtask

    task automatic check_reset(input string tag);
        obs_t r;
        r = '{x: 10'd0, y: 10'd0, hs: 1'b1, vs: 1'b1, de: 1'b1, ls: 1'b1, fs: 1'b1, fc: 8'd0};
        compare({tag, "_dflt"}, obs_a(), r);
        compare({tag, "_small"}, obs_b(), r);
    endtask

    // Drive ena for the next edge and queue what both instances must show after it.
    task automatic step(input bit e);
        @(posedge clk);
        #2;
        ena = e;
        if (e) begin
            pos_a++;
            if (pos_a == 800 * 525) begin
                pos_a = 0;
                fr_a++;
            end
            pos_b++;
            if (pos_b == 8 * 7) begin
                pos_b = 0;
                fr_b++;
            end
        end
        q_a.push_back(exp_a());
        q_b.push_back(exp_b());
    endtask

    task automatic release_reset();
        ena = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        pos_a = 0; fr_a = 0; pos_b = 0; fr_b = 0;
    endtask

    // Monitor: every edge, compare what the DUTs show against the queued prediction.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (q_a.size() > 0) compare("dflt", obs_a(), q_a.pop_front());
            if (q_b.size() > 0) compare("small", obs_b(), q_b.pop_front());
        end
    end

    initial begin
        rst_n = 1'b0;
        ena   = 1'b0;
        #12;
        check_reset("rst_init");
        ena = 1'b1;
        repeat (3) @(posedge clk);
        #3;
        check_reset("rst_held_clk");
        release_reset();

        // One full default line plus a bit, ena held high.
        repeat (805) step(1'b1);

        // Park the default instance at x=655 and stall for 7 clocks.
        while (exp_a().x != 10'd655) step(1'b1);
        repeat (7) step(1'b0);
        repeat (3) step(1'b1);

        // Random ena: enough tiny-raster frames to roll frame_count past 255.
        repeat (20000) step($urandom_range(0, 3) != 0);

        // Asynchronous reset between edges, mid-frame.
        @(posedge clk);
        #3;
        ena = 1'b1;
        #3;
        rst_n = 1'b0;
        #1;
        check_reset("rst_async");
        repeat (2) @(posedge clk);
        #3;
        check_reset("rst_async_held");
        release_reset();
        repeat (300) step($urandom_range(0, 4) != 0);

        @(posedge clk);
        #3;
        n_tests++;
        if (q_a.size() != 0 || q_b.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d/%0d pending, want 0/0", q_a.size(), q_b.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
